// File: rtl/video_io_pkg.sv
// Shared constants, state encoding and helpers for the video I/O register block.
package video_io_pkg;

    // Port offsets from the I/O base address
    localparam logic [3:0] OFF_MODE  = 4'h8;
    localparam logic [3:0] OFF_COLOR = 4'h9;
    localparam logic [3:0] OFF_TANDY = 4'hA;   // write: Tandy index/data, read: status
    localparam logic [3:0] OFF_RSVD  = 4'hE;   // reserved, writes have no effect

    // Tandy indexed-register codes
    localparam logic [4:0] IDX_BORDER   = 5'h02;
    localparam logic [4:0] IDX_PAL_BASE = 5'h10;

    // Reset constants
    localparam logic [7:0] MODE_RST = 8'h29;

    // Wait-state generator states
    typedef enum logic [1:0] {
        WG_IDLE = 2'd0,
        WG_WAIT = 2'd1,
        WG_HOLD = 2'd2
    } wg_state_t;

    // Status byte as seen by the CPU on a read of the status port
    function automatic logic [7:0] status_byte(input logic vs, input logic de);
        return {4'b1111, vs, 2'b10, ~de};
    endfunction

endpackage

// File: rtl/video_io_waitgen.sv
// ISA wait-state generator: holds bus_rdy low for WAIT_CYCLES clocks once a
// decoded I/O strobe is seen, then keeps it high until both strobes release.
module video_io_waitgen
    import video_io_pkg::*;
#(
    parameter int WAIT_CYCLES = 4
)(
    input  logic clk,
    input  logic reset,
    input  logic i_req,       // decoded port with a synced strobe low
    input  logic i_ior_s2,
    input  logic i_iow_s2,
    output logic o_rdy
);

    wg_state_t  r_state;
    logic [3:0] r_cnt;
    logic       r_rdy;

    // Wait FSM with registered ready output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WG_IDLE;
            r_cnt   <= 4'd0;
            r_rdy   <= 1'b1;
        end else begin
            case (r_state)
                WG_IDLE: begin
                    if (i_req) begin
                        r_state <= WG_WAIT;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_rdy   <= 1'b0;
                    end
                end
                WG_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    // Counter reaches zero on this edge: release the bus
                    if (r_cnt == 4'd1) begin
                        r_state <= WG_HOLD;
                        r_rdy   <= 1'b1;
                    end
                end
                WG_HOLD: begin
                    r_rdy <= 1'b1;
                    if (i_ior_s2 && i_iow_s2)
                        r_state <= WG_IDLE;
                end
                default: begin
                    r_state <= WG_IDLE;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    assign o_rdy = r_rdy;

endmodule

// File: rtl/video_io_regs.sv
// ISA I/O register block for the CGA/Tandy video path: mode/colour registers,
// status port, Tandy index/data port with vsync-committed palette and border.
module video_io_regs
    import video_io_pkg::*;
#(
    parameter logic [15:0] IO_BASE_ADDR = 16'h3D0,
    parameter int          PAL_DEPTH    = 16,
    parameter int          PAL_WIDTH    = 4,
    parameter int          VSYNC_COMMIT = 1,
    parameter int          USE_BUS_WAIT = 0,
    parameter int          WAIT_CYCLES  = 4
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [14:0]                  bus_a,
    input  logic                         bus_ior_l,
    input  logic                         bus_iow_l,
    input  logic                         bus_aen,
    input  logic [7:0]                   bus_d,
    output logic [7:0]                   bus_out,
    output logic                         bus_dir,
    output logic                         bus_rdy,
    input  logic                         vsync,
    input  logic                         display_enable,
    output logic [7:0]                   mode_reg,
    output logic [7:0]                   color_reg,
    input  logic [$clog2(PAL_DEPTH)-1:0] pal_rd_idx,
    output logic [PAL_WIDTH-1:0]         pal_rd_data,
    output logic [3:0]                   border_color,
    output logic                         reg_update
);

    localparam int IDX_W = $clog2(PAL_DEPTH);

    // Strobe synchronisers (idle high) and registered vsync
    logic r_ior_s1, r_ior_s2, r_ior_s3;
    logic r_iow_s1, r_iow_s2, r_iow_s3;
    logic r_vsync_q;

    // Programmer-visible state
    logic [7:0]           r_mode_reg;
    logic [7:0]           r_color_reg;
    logic                 r_ff;
    logic [4:0]           r_index;
    logic [3:0]           r_border_shadow;
    logic [3:0]           r_border_act;
    logic [PAL_WIDTH-1:0] r_pal_shadow [PAL_DEPTH];
    logic [PAL_WIDTH-1:0] r_pal_act    [PAL_DEPTH];
    logic                 r_reg_update;

    // Decode and events
    logic [14:0]          w_off;
    logic                 w_hit_lo;
    logic                 w_dec_mode;
    logic                 w_dec_color;
    logic                 w_dec_tandy;
    logic                 w_iow_ev;
    logic                 w_ior_ev;
    logic                 w_tandy_data_wr;
    logic [4:0]           w_pal_off;
    logic                 w_pal_hit;
    logic [IDX_W-1:0]     w_pal_n;
    logic                 w_shadow_wr;
    logic                 w_commit;
    logic [3:0]           w_border_next;
    logic [PAL_WIDTH-1:0] w_pal_next [PAL_DEPTH];

    // Offset from the base; only +0..+F of the base decode at all
    assign w_off       = bus_a - IO_BASE_ADDR[14:0];
    assign w_hit_lo    = ~bus_aen && (w_off[14:4] == 11'd0);
    assign w_dec_mode  = w_hit_lo && (w_off[3:0] == OFF_MODE);
    assign w_dec_color = w_hit_lo && (w_off[3:0] == OFF_COLOR);
    assign w_dec_tandy = w_hit_lo && (w_off[3:0] == OFF_TANDY);

    // One event per strobe: the synced strobe has just gone low
    assign w_iow_ev = r_iow_s3 & ~r_iow_s2;
    assign w_ior_ev = r_ior_s3 & ~r_ior_s2;

    assign w_tandy_data_wr = w_iow_ev && w_dec_tandy && r_ff;
    assign w_pal_off       = r_index - IDX_PAL_BASE;
    assign w_pal_hit       = (r_index >= IDX_PAL_BASE) && (w_pal_off < 5'(PAL_DEPTH));
    assign w_pal_n         = w_pal_off[IDX_W-1:0];

    // Synchronise the asynchronous ISA strobes and register vsync for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ior_s1  <= 1'b1;
            r_ior_s2  <= 1'b1;
            r_ior_s3  <= 1'b1;
            r_iow_s1  <= 1'b1;
            r_iow_s2  <= 1'b1;
            r_iow_s3  <= 1'b1;
            r_vsync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let each flop take its neighbour's old value, forming a true chain.
            r_ior_s1  <= bus_ior_l;
            r_ior_s2  <= r_ior_s1;
            r_ior_s3  <= r_ior_s2;
            r_iow_s1  <= bus_iow_l;
            r_iow_s2  <= r_iow_s1;
            r_iow_s3  <= r_iow_s2;
            r_vsync_q <= vsync;
        end
    end

    // Next shadow contents including any Tandy data write in this cycle
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        w_pal_next    = r_pal_shadow;
        w_border_next = r_border_shadow;
        w_shadow_wr   = 1'b0;
        if (w_tandy_data_wr) begin
            if (r_index == IDX_BORDER) begin
                w_border_next = bus_d[3:0];
                w_shadow_wr   = 1'b1;
            end else if (w_pal_hit) begin
                w_pal_next[w_pal_n] = bus_d[PAL_WIDTH-1:0];
                w_shadow_wr         = 1'b1;
            end
        end
    end

    // Commit on the vsync rising edge, or on every shadow write when immediate
    assign w_commit = (VSYNC_COMMIT != 0) ? (vsync & ~r_vsync_q) : w_shadow_wr;

    // Direct registers, Tandy index flip-flop and the shadow/active register pairs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode_reg      <= MODE_RST;
            r_color_reg     <= 8'h00;
            r_ff            <= 1'b0;
            r_index         <= 5'd0;
            r_border_shadow <= 4'd0;
            r_border_act    <= 4'd0;
            r_reg_update    <= 1'b0;
            // NOTE: the palette is a handful of flops with defined reset contents, so it is reset explicitly rather than treated as RAM.
            for (int i = 0; i < PAL_DEPTH; i++) begin
                r_pal_shadow[i] <= PAL_WIDTH'(i);
                r_pal_act[i]    <= PAL_WIDTH'(i);
            end
        end else begin
            r_reg_update <= w_commit;

            if (w_iow_ev && w_dec_mode)
                r_mode_reg <= bus_d;
            if (w_iow_ev && w_dec_color)
                r_color_reg <= bus_d;

            if (w_iow_ev && w_dec_tandy) begin
                if (!r_ff) begin
                    r_index <= bus_d[4:0];
                    r_ff    <= 1'b1;
                end else begin
                    r_ff    <= 1'b0;
                end
            end else if (w_ior_ev && w_dec_tandy) begin
                // Reading status re-arms the port for an index write
                r_ff <= 1'b0;
            end

            r_pal_shadow    <= w_pal_next;
            r_border_shadow <= w_border_next;
            if (w_commit) begin
                r_pal_act    <= w_pal_next;
                r_border_act <= w_border_next;
            end
        end
    end

    // Optional wait-state generator on decoded +8..+F cycles
    generate
        if (USE_BUS_WAIT != 0) begin : g_wait
            logic w_wait_req;
            assign w_wait_req = w_hit_lo && w_off[3] && (~r_ior_s2 || ~r_iow_s2);
            video_io_waitgen #(
                .WAIT_CYCLES (WAIT_CYCLES)
            ) u_waitgen (
                .clk      (clk),
                .reset    (reset),
                .i_req    (w_wait_req),
                .i_ior_s2 (r_ior_s2),
                .i_iow_s2 (r_iow_s2),
                .o_rdy    (bus_rdy)
            );
        end else begin : g_nowait
            assign bus_rdy = 1'b1;
        end
    endgenerate

    assign bus_dir      = w_dec_tandy && ~bus_ior_l;
    assign bus_out      = bus_dir ? status_byte(vsync, display_enable) : 8'h00;
    assign mode_reg     = r_mode_reg;
    assign color_reg    = r_color_reg;
    assign pal_rd_data  = r_pal_act[pal_rd_idx];
    assign border_color = r_border_act;
    assign reg_update   = r_reg_update;

endmodule

// File: tb/tb_video_io_regs.sv
// Directed bench for video_io_regs: a default instance (16x4 palette, vsync
// commit, no waits) and a small instance (8 entries, wait states enabled).
module tb_video_io_regs;

    localparam logic [14:0] BASE = 15'h3D0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] bus_a = BASE;
    logic        bus_ior_l = 1'b1;
    logic        bus_iow_l = 1'b1;
    logic        bus_aen = 1'b0;
    logic [7:0]  bus_d = 8'h00;
    logic        vsync = 1'b0;
    logic        display_enable = 1'b1;
    logic [3:0]  pal_idx = 4'd0;
    logic [2:0]  pal_idx_w = 3'd0;

    logic [7:0]  bus_out, bus_out_w, mode_reg, mode_reg_w, color_reg, color_reg_w;
    logic        bus_dir, bus_dir_w, bus_rdy, bus_rdy_w, reg_update, reg_update_w;
    logic [3:0]  pal_data, pal_data_w, border, border_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    video_io_regs u_dut (
        .clk(clk), .reset(reset), .bus_a(bus_a), .bus_ior_l(bus_ior_l),
        .bus_iow_l(bus_iow_l), .bus_aen(bus_aen), .bus_d(bus_d),
        .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
        .vsync(vsync), .display_enable(display_enable),
        .mode_reg(mode_reg), .color_reg(color_reg),
        .pal_rd_idx(pal_idx), .pal_rd_data(pal_data),
        .border_color(border), .reg_update(reg_update)
    );

    video_io_regs #(
        .PAL_DEPTH(8), .USE_BUS_WAIT(1), .WAIT_CYCLES(4)
    ) u_dut_w (
        .clk(clk), .reset(reset), .bus_a(bus_a), .bus_ior_l(bus_ior_l),
        .bus_iow_l(bus_iow_l), .bus_aen(bus_aen), .bus_d(bus_d),
        .bus_out(bus_out_w), .bus_dir(bus_dir_w), .bus_rdy(bus_rdy_w),
        .vsync(vsync), .display_enable(display_enable),
        .mode_reg(mode_reg_w), .color_reg(color_reg_w),
        .pal_rd_idx(pal_idx_w), .pal_rd_data(pal_data_w),
        .border_color(border_w), .reg_update(reg_update_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe held low for 4 clocks, then 4 idle clocks so the synchronisers settle
    task automatic io_write(input logic [3:0] off, input logic [7:0] data);
        @(negedge clk);
        bus_a = BASE + 15'(off);
        bus_d = data;
        bus_iow_l = 1'b0;
        repeat (4) @(negedge clk);
        bus_iow_l = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic io_read(input logic [3:0] off, output logic [7:0] data, output logic dir);
        @(negedge clk);
        bus_a = BASE + 15'(off);
        bus_ior_l = 1'b0;
        #1;
        data = bus_out;
        dir  = bus_dir;
        repeat (4) @(negedge clk);
        bus_ior_l = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Raise vsync, count reg_update pulses from the default instance
    task automatic vsync_rise(output int pulses);
        pulses = 0;
        @(negedge clk);
        vsync = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (reg_update) pulses++;
        end
        vsync = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (reg_update) pulses++;
        end
    endtask

    task automatic chk_pal(input string tag, input logic [3:0] idx, input logic [3:0] exp);
        pal_idx = idx;
        #1;
        check(tag, pal_data, exp);
    endtask

    task automatic chk_pal_w(input string tag, input logic [2:0] idx, input logic [3:0] exp);
        pal_idx_w = idx;
        #1;
        check(tag, pal_data_w, exp);
    endtask

    initial begin
        logic [7:0] rd;
        logic       dir;
        int         pulses;
        int         lows;
        int         first_low;
        logic [3:0] exp_w [8];

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mode", mode_reg, 8'h29);
        check("rst_color", color_reg, 8'h00);
        check("rst_border", border, 4'h0);
        check("rst_rdy", bus_rdy, 1'b1);
        check("rst_rdy_w", bus_rdy_w, 1'b1);
        check("rst_upd", reg_update, 1'b0);
        check("rst_bus_out_idle", bus_out, 8'h00);
        chk_pal("rst_pal5", 4'd5, 4'd5);

        // ---------------- status reads ----------------
        // {1111, vsync, 10, ~DE}: vsync=1 DE=0 -> 1111_1101
        vsync = 1'b1;
        display_enable = 1'b0;
        io_read(4'hA, rd, dir);
        check("stat_vs1_de0", rd, 8'hFD);
        check("stat_dir", dir, 1'b1);
        vsync = 1'b0;
        display_enable = 1'b1;
        io_read(4'hA, rd, dir);
        check("stat_vs0_de1", rd, 8'hF4);
        io_read(4'h8, rd, dir);
        check("rd_mode_port_out", rd, 8'h00);
        check("rd_mode_port_dir", dir, 1'b0);
        repeat (4) @(negedge clk);

        // ---------------- mode / colour / reserved ----------------
        io_write(4'h8, 8'h5A);
        check("mode_wr", mode_reg, 8'h5A);
        io_write(4'h9, 8'h3C);
        check("color_wr", color_reg, 8'h3C);
        io_write(4'hE, 8'hFF);
        check("rsvd_mode", mode_reg, 8'h5A);
        check("rsvd_color", color_reg, 8'h3C);
        bus_aen = 1'b1;
        io_write(4'h8, 8'h11);
        bus_aen = 1'b0;
        check("aen_inhibit", mode_reg, 8'h5A);

        // ---------------- palette vsync commit ----------------
        io_write(4'hA, 8'h13);
        io_write(4'hA, 8'h0C);
        chk_pal("pal3_before_vs", 4'd3, 4'd3);
        vsync_rise(pulses);
        check("pal3_after_vs", pal_data, 4'hC);
        check("pal3_upd_pulses", pulses, 1);
        chk_pal("pal4_untouched", 4'd4, 4'd4);

        // ---------------- status read resets ff ----------------
        io_write(4'hA, 8'h10);
        io_read(4'hA, rd, dir);
        io_write(4'hA, 8'h02);
        io_write(4'hA, 8'h07);
        check("border_before_vs", border, 4'h0);
        vsync_rise(pulses);
        check("border_after_vs", border, 4'h7);
        chk_pal("pal0_not_written", 4'd0, 4'd0);

        // ---------------- last write wins ----------------
        io_write(4'hA, 8'h11);
        io_write(4'hA, 8'h06);
        io_write(4'hA, 8'h11);
        io_write(4'hA, 8'h09);
        vsync_rise(pulses);
        chk_pal("lww_pal1", 4'd1, 4'd9);

        // ---------------- write and commit in the same cycle ----------------
        io_write(4'hA, 8'h12);          // index 2 of the palette
        @(negedge clk);
        bus_a = BASE + 15'hA;
        bus_d = 8'h0E;
        bus_iow_l = 1'b0;
        @(negedge clk);                 // edge 1: s1 low
        @(negedge clk);                 // edge 2: s2 low, write event pending
        vsync = 1'b1;                   // edge 3 both writes the shadow and commits
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (reg_update) pulses++;
        end
        bus_iow_l = 1'b1;
        vsync = 1'b0;
        repeat (4) @(negedge clk);
        chk_pal("same_cycle_pal2", 4'd2, 4'hE);
        check("same_cycle_pulses", pulses, 1);

        // ---------------- out-of-range index with 8-entry palette ----------------
        io_write(4'hA, 8'h1F);
        io_write(4'hA, 8'h05);
        vsync_rise(pulses);
        exp_w = '{4'h0, 4'h9, 4'hE, 4'hC, 4'h4, 4'h5, 4'h6, 4'h7};
        for (int i = 0; i < 8; i++)
            chk_pal_w($sformatf("pal8_idx%0d", i), 3'(i), exp_w[i]);
        chk_pal("pal16_idx15", 4'd15, 4'h5);
        io_write(4'hA, 8'h17);          // must be taken as an index
        io_write(4'hA, 8'h0A);
        vsync_rise(pulses);
        chk_pal_w("pal8_after_reindex", 3'd7, 4'hA);

        // ---------------- wait-state generator ----------------
        lows = 0;
        first_low = -1;
        @(negedge clk);
        bus_a = BASE + 15'h8;
        bus_ior_l = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!bus_rdy_w) begin
                lows++;
                if (first_low < 0) first_low = k;
            end
            if (!bus_rdy) check("nowait_rdy_high", bus_rdy, 1'b1);
        end
        bus_ior_l = 1'b1;
        repeat (5) @(negedge clk);
        check("wait_low_cycles", lows, 4);
        // edges: s1 sample, s2 sample, FSM register -> first low after edge 3
        check("wait_first_low_edge", first_low, 3);
        check("wait_rdy_idle", bus_rdy_w, 1'b1);

        // ---------------- asynchronous reset mid-operation ----------------
        io_write(4'hA, 8'h02);          // leave ff = 1 pending
        io_write(4'h8, 8'h77);
        @(negedge clk);
        bus_a = BASE + 15'h9;
        bus_ior_l = 1'b0;
        repeat (4) @(negedge clk);
        check("midop_rdy_low", bus_rdy_w, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_rdy", bus_rdy_w, 1'b1);
        check("async_rst_mode", mode_reg, 8'h29);
        check("async_rst_border", border, 4'h0);
        chk_pal("async_rst_pal3", 4'd3, 4'd3);
        bus_ior_l = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        io_write(4'hA, 8'h12);          // ff was lost: this is an index
        io_write(4'hA, 8'h05);
        vsync_rise(pulses);
        chk_pal("ff_lost_pal2", 4'd2, 4'h5);
        check("ff_lost_border", border, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
